// File: rtl/cw_enc_pkg.sv
// Shared types and default widths for the constant-weight encoder controller.
package cw_enc_pkg;

  localparam int N_W = 19;
  localparam int T_W = 4;
  localparam int D_W = 18;
  localparam int U_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOOKUP,
    FLAG,
    INDEX,
    EMIT,
    FILL,
    DONE
  } state_t;

endpackage

// File: rtl/cw_encode_ctrl_best_d.sv
// Registered best_d lookup: d = 2^u with u the largest value such that
// 2*t*2^u <= n-t (u = 0 when none fits), so n-d >= t always holds for n > t.
module cw_encode_ctrl_best_d #(
  parameter int N_W = 19,
  parameter int T_W = 4,
  parameter int D_W = 18,
  parameter int U_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N_W-1:0] n,
  input  logic [T_W-1:0] t,
  output logic [D_W-1:0] d,
  output logic [U_W-1:0] u_minus_1
);

  logic [31:0]    diff;
  logic [U_W-1:0] u_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    diff  = 32'(n) - 32'(t);
    u_sel = '0;
    for (int u = 1; u < D_W; u++) begin
      if ((32'(t) << (u + 1)) <= diff) u_sel = U_W'(u);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d         <= '0;
      u_minus_1 <= '0;
    end else begin
      d         <= D_W'(1) << u_sel;
      u_minus_1 <= u_sel - U_W'(1);
    end
  end

endmodule

// File: rtl/cw_encode_ctrl.sv
// Constant-weight encoder sequencer: walks (n, t), consumes message bits and
// emits run-length deltas. Optional bit counter port under CW_CTRL_BITCNT_EN.
module cw_encode_ctrl #(
  parameter int N_W = cw_enc_pkg::N_W,
  parameter int T_W = cw_enc_pkg::T_W,
  parameter int D_W = cw_enc_pkg::D_W,
  parameter int U_W = cw_enc_pkg::U_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n_init,
  input  logic [T_W-1:0] t_init,
  input  logic           bit_valid,
  input  logic           bit_data,
  output logic           bit_ready,
  output logic           delta_valid,
  output logic [N_W-1:0] delta,
  input  logic           delta_ready,
  output logic           busy,
  output logic           done
`ifdef CW_CTRL_BITCNT_EN
  ,
  output logic [15:0]    bits_used
`endif
);

  import cw_enc_pkg::*;

  state_t         state;
  logic [N_W-1:0] n_r;
  logic [T_W-1:0] t_r;
  logic [N_W-1:0] skip_r;
  logic [D_W-1:0] d_r;
  logic [U_W:0]   u_r;
  logic [D_W-1:0] idx_r;
  logic [U_W:0]   cnt_r;

  logic [D_W-1:0] bd_d;
  logic [U_W-1:0] bd_um1;
  logic           bit_accept;

  cw_encode_ctrl_best_d #(
    .N_W(N_W),
    .T_W(T_W),
    .D_W(D_W),
    .U_W(U_W)
  ) u_best_d (
    .clk      (clk),
    .rst_n    (rst_n),
    .n        (n_r),
    .t        (t_r),
    .d        (bd_d),
    .u_minus_1(bd_um1)
  );

  // Handshake outputs decode the state register only, never the peer's valid/ready.
  assign bit_ready   = (state == FLAG) || (state == INDEX);
  assign delta_valid = (state == EMIT) || (state == FILL);
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign bit_accept  = bit_ready && bit_valid;

  always_comb begin
    delta = '0;
    case (state)
      EMIT:    delta = skip_r + N_W'(idx_r);
      FILL:    delta = skip_r;
      default: delta = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      n_r    <= '0;
      t_r    <= '0;
      skip_r <= '0;
      d_r    <= '0;
      u_r    <= '0;
      idx_r  <= '0;
      cnt_r  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (start) begin
            n_r    <= n_init;
            t_r    <= t_init;
            skip_r <= '0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (t_r == '0)               state <= DONE;
          else if (N_W'(t_r) == n_r)   state <= FILL;
          else                         state <= LOOKUP;
        end
        LOOKUP: begin
          // n_r/t_r settled in CHECK, so the lookup register is already valid here.
          d_r   <= bd_d;
          u_r   <= {1'b0, bd_um1} + (U_W+1)'(1);
          state <= FLAG;
        end
        FLAG: begin
          if (bit_accept) begin
            if (bit_data) begin
              skip_r <= skip_r + N_W'(d_r);
              n_r    <= n_r - N_W'(d_r);
              state  <= CHECK;
            end else begin
              idx_r <= '0;
              if (d_r == D_W'(1)) begin
                state <= EMIT;
              end else begin
                cnt_r <= u_r;
                state <= INDEX;
              end
            end
          end
        end
        INDEX: begin
          if (bit_accept) begin
            idx_r <= {idx_r[D_W-2:0], bit_data};
            cnt_r <= cnt_r - (U_W+1)'(1);
            if (cnt_r == (U_W+1)'(1)) state <= EMIT;
          end
        end
        EMIT: begin
          if (delta_ready) begin
            n_r    <= n_r - N_W'(idx_r) - N_W'(1);
            t_r    <= t_r - T_W'(1);
            skip_r <= '0;
            state  <= CHECK;
          end
        end
        FILL: begin
          if (delta_ready) begin
            t_r    <= t_r - T_W'(1);
            skip_r <= '0;
            if (t_r == T_W'(1)) state <= CHECK;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CW_CTRL_BITCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_used <= '0;
    end else if ((state == IDLE) && start) begin
      bits_used <= '0;
    end else if (bit_accept && (bits_used != 16'hFFFF)) begin
      bits_used <= bits_used + 16'd1;
    end
  end
`endif

endmodule

// File: doc/cw_encode_ctrl.md
# cw_encode_ctrl

Sequencer for the constant-weight encoder datapath. It owns the running (n, t) pair, drives the `best_d` lookup once per iteration and consumes the serial message bit stream. It emits one run-length delta per nonzero position until t reaches 0. It sits between the message bit source and the position/delta sink in the encoder top level.

## Interface
- `N_W`, default 19: width of n and delta.
- `T_W`, default 4: width of t.
- `D_W`, default 18: width of d from `best_d`.
- `U_W`, default 5: width of `u_minus_1` from `best_d`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin encoding; sampled only in IDLE.
- `n_init` input N_W: code length.
- `t_init` input T_W: weight.
- `bit_valid` input 1: message bit available.
- `bit_data` input 1: message bit.
- `bit_ready` output 1: controller consumes `bit_data` this cycle when `bit_valid` is also high.
- `delta_valid` output 1: `delta` holds an output.
- `delta` output N_W: zeros preceding the next one-position.
- `delta_ready` input 1: sink accepts `delta`.
- `busy` output 1: high from start acceptance until DONE.
- `done` output 1: one-cycle pulse at completion.

## Operation
- Registers: `n_r` (N_W), `t_r` (T_W), `skip_r` (N_W), `d_r` (D_W), `u_r` (U_W+1), `idx_r` (D_W), `cnt_r` (U_W+1).
- IDLE: on `start`, load `n_r`=`n_init`, `t_r`=`t_init`, `skip_r`=0, and go to CHECK.
- CHECK:
  - `t_r`==0 → DONE.
  - `n_r`==`t_r` → FILL.
  - Otherwise → LOOKUP.
- LOOKUP: `best_d` is driven from `n_r`/`t_r`. Stay 1 cycle, then → FLAG.
- FLAG: latch `d_r`=d and `u_r`=`u_minus_1`+1. Assert `bit_ready` and wait for `bit_valid`.
  - Bit 1: `skip_r`+=d, `n_r`-=d → CHECK.
  - Bit 0 with d==1: `idx_r`=0 → EMIT.
  - Bit 0 otherwise: `idx_r`=0, `cnt_r`=`u_r` → INDEX.
- INDEX: assert `bit_ready`. Each accepted bit does `idx_r`=(`idx_r`<<1)|`bit_data` (MSB first) and `cnt_r`-=1. At `cnt_r`==1 with a bit accepted → EMIT.
- EMIT: `delta`=`skip_r`+`idx_r`, `delta_valid`=1. On `delta_ready`: `n_r`-=`idx_r`+1, `t_r`-=1, `skip_r`=0 → CHECK.
- FILL: emit `delta`=`skip_r` and then 0 for each remaining position, with no bits consumed. `t_r`-=1 per handshake. At `t_r`==0 → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Arithmetic:
  - All subtractions are unsigned N_W.
  - `best_d` guarantees `n_r`-d ≥ `t_r`. No underflow handling is required.
  - `skip_r`+`idx_r` < `n_init` always, so no overflow.
- `start` while busy is ignored. `bit_data` is ignored when `bit_ready` is low.

## Timing
- Reset values: `bit_ready`=0, `delta_valid`=0, `delta`=0, `busy`=0, `done`=0, state=IDLE, all registers 0.
- Reset mid-operation: immediate return to IDLE. No partial delta is emitted.
- `bit_ready` and `delta_valid` are never high in the same cycle. Both are registered-state decodes and do not combinationally depend on `bit_valid` or `delta_ready`.
- `delta` is stable while `delta_valid`=1 and `delta_ready`=0.
- Latency per iteration with bits always valid and sink always ready:
  - Flag-1 iteration: 3 cycles (CHECK, LOOKUP, FLAG).
  - Index iteration: 4+u cycles.
  - `busy` rises the cycle after `start`.
  - `done` follows the last EMIT handshake by 2 cycles (CHECK, DONE).
- `t_init`=0: `done` 2 cycles after `start`.

## Configuration
- `CW_CTRL_BITCNT_EN` defined: adds output `bits_used` [15:0]. It is cleared on start, increments on every accepted bit and saturates at 16'hFFFF.
- Undefined: no port, no counter logic.

## Structure
- Package `cw_enc_pkg`: state enum (IDLE, CHECK, LOOKUP, FLAG, INDEX, EMIT, FILL, DONE) and width constants N_W/T_W/D_W/U_W.
- One sub-module: a `best_d` instance with 1-cycle registered latency, driven from `n_r`/`t_r`.

## Test plan
- `n_init`=3, `t_init`=3 → deltas 0,0,0. No `bit_ready`. `done` pulses.
- `t_init`=0, `start` → no delta. `done` pulses 2 cycles after `start`.
- With a `best_d` stub returning d=4, `u_minus_1`=1: `n_init`=16, `t_init`=1, bits 1,0,1,0 → single delta 6, then `done`. Final `n_r`=9, `t_r`=0.
- With a stub returning d=1: `n_init`=5, `t_init`=2, bits 0 then 0 → deltas 0,0. FLAG consumes one bit each and no index bits are read.
- Hold `delta_ready`=0 for 5 cycles during EMIT → `delta` stable, `bit_ready`=0, no state change.
- Assert `rst_n`=0 in INDEX → all outputs 0 immediately. A new `start` then produces a correct full sequence.
